// File: rtl/adc_bram_pkg.sv
// Shared types for the ADC/BRAM blocks.
// Streamer FSM encoding lives here so sibling blocks agree on it.
package adc_bram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } stream_state_e;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO holding BRAM read returns.
// The head word is presented combinationally on pop_data.
module skid_fifo2 #(
  parameter int RAM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  logic [RAM_WIDTH-1:0] push_data,
  input  logic                 pop,
  output logic [RAM_WIDTH-1:0] pop_data,
  output logic [1:0]           occupancy
);

  logic [RAM_WIDTH-1:0] mem0;
  logic [RAM_WIDTH-1:0] mem1;
  logic                 wp;
  logic                 rp;

  assign pop_data = rp ? mem1 : mem0;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem0      <= '0;
      mem1      <= '0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      occupancy <= 2'd0;
    end else if (flush) begin
      wp        <= 1'b0;
      rp        <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (push) begin
        if (wp) mem1 <= push_data;
        else    mem0 <= push_data;
        wp <= ~wp;
      end
      if (pop)
        rp <= ~rp;
      occupancy <= occupancy + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/bram_read_streamer.sv
// Streams a burst of words from block RAM to a ready/valid consumer.
// Reads are credit-limited so the 2-entry buffer can never overflow.
module bram_read_streamer
  import adc_bram_pkg::*;
#(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [RAM_ADDR_BITS-1:0] start_address,
  input  logic [RAM_ADDR_BITS:0]   read_length,
  output logic                     read_enable,
  output logic [RAM_ADDR_BITS-1:0] read_address,
  input  logic [RAM_WIDTH-1:0]     read_data,
  output logic [RAM_WIDTH-1:0]     out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  localparam logic [RAM_ADDR_BITS:0]   LEN_ONE  = 1;
  localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = 1;

  stream_state_e          state;
  logic [RAM_ADDR_BITS:0] reads_left;
  logic [RAM_ADDR_BITS:0] words_left;
  logic                   rd_pend;
  logic [1:0]             occ;
  logic [2:0]             credit;
  logic                   pop;
  logic                   issue;

  assign pop    = out_valid & out_ready;
  assign credit = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop};
  assign issue  = (state == ST_FETCH) && (reads_left != '0)
               && (credit < 3'd2);

  assign read_enable = issue;
  assign out_valid   = (occ != 2'd0);
  assign busy        = (state != ST_IDLE);

  skid_fifo2 #(
    .RAM_WIDTH(RAM_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (rd_pend),
    .push_data (read_data),
    .pop       (pop),
    .pop_data  (out_data),
    .occupancy (occ)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      read_address <= '0;
      reads_left   <= '0;
      words_left   <= '0;
      rd_pend      <= 1'b0;
      done         <= 1'b0;
    end else if (abort) begin
      state      <= ST_IDLE;
      reads_left <= '0;
      words_left <= '0;
      rd_pend    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_pend <= issue;
      if (pop)
        words_left <= words_left - LEN_ONE;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (read_length == '0) begin
              done <= 1'b1;
            end else begin
              state        <= ST_FETCH;
              read_address <= start_address;
              reads_left   <= read_length;
              words_left   <= read_length;
            end
          end
        end
        ST_FETCH: begin
          if (issue) begin
            read_address <= read_address + ADDR_ONE;
            reads_left   <= reads_left - LEN_ONE;
            if (reads_left == LEN_ONE)
              state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && words_left == LEN_ONE) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_read_streamer.sv
// Scoreboard bench for bram_read_streamer.
// Expected addresses/words are queued at start; a monitor checks them.
module tb_bram_read_streamer;

  localparam int W = 8;
  localparam int A = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [A-1:0] start_address = '0;
  logic [A:0]   read_length = '0;
  logic         read_enable;
  logic [A-1:0] read_address;
  logic [W-1:0] read_data = '0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [A-1:0] exp_addr[$];
  logic [W-1:0] exp_data[$];
  int           outstanding = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  bram_read_streamer #(
    .RAM_WIDTH(W),
    .RAM_ADDR_BITS(A)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .start_address (start_address),
    .read_length   (read_length),
    .read_enable   (read_enable),
    .read_address  (read_address),
    .read_data     (read_data),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // RAM model: data[a] = a[7:0], registered read
  always @(posedge clk)
    if (read_enable) read_data <= read_address[7:0];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic pop_s;
    logic [A-1:0] ea;
    logic [W-1:0] ed;
    pop_s = out_valid && out_ready;
    if (prev_stall) begin
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_data", int'(out_data), int'(prev_data));
    end
    if (read_enable) begin
      chk("credit", int'(outstanding - int'(pop_s) < 2), 1);
      if (exp_addr.size() == 0) begin
        chk("unexpected_read", 1, 0);
      end else begin
        ea = exp_addr.pop_front();
        chk("read_addr", int'(read_address), int'(ea));
      end
    end
    if (pop_s) begin
      if (exp_data.size() == 0) begin
        chk("unexpected_word", 1, 0);
      end else begin
        ed = exp_data.pop_front();
        chk("out_data", int'(out_data), int'(ed));
      end
    end
    outstanding = outstanding + int'(read_enable) - int'(pop_s);
    prev_stall = out_valid && !out_ready && !abort && !rst;
    prev_data = out_data;
    if (abort || rst) outstanding = 0;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic queue_burst(input logic [A-1:0] a, input int len);
    logic [A-1:0] x;
    x = a;
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(x);
      exp_data.push_back(x[7:0]);
      x = x + 1'b1;
    end
  endtask

  task automatic do_start(input logic [A-1:0] a, input int len);
    queue_burst(a, len);
    start_address = a;
    read_length = (A+1)'(len);
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick;
    end
    chk({name, "_done"}, int'(seen), 1);
    chk({name, "_busy_at_done"}, int'(busy), 0);
    chk({name, "_dq_empty"}, exp_data.size(), 0);
    chk({name, "_aq_empty"}, exp_addr.size(), 0);
    tick;
    chk({name, "_done_1cyc"}, int'(done), 0);
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_re"}, int'(read_enable), 0);
    chk({name, "_addr"}, int'(read_address), 0);
    chk({name, "_ov"}, int'(out_valid), 0);
    chk({name, "_od"}, int'(out_data), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
  endtask

  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    #1;
    tick;
    tick;
    chk_reset_outs("reset");
    rst = 1'b0;
    tick;

    // basic burst with cycle-accurate latency
    do_start(16'h0010, 4);
    chk("basic_re_n1", int'(read_enable), 1);
    chk("basic_addr_n1", int'(read_address), 16'h0010);
    chk("basic_busy_n1", int'(busy), 1);
    tick;
    chk("basic_ov_n2", int'(out_valid), 0);
    tick;
    chk("basic_ov_n3", int'(out_valid), 1);
    chk("basic_od_n3", int'(out_data), 8'h10);
    tick;
    tick;
    tick;
    chk("basic_ov_n6", int'(out_valid), 1);
    chk("basic_od_n6", int'(out_data), 8'h13);
    tick;
    chk("basic_done_n7", int'(done), 1);
    chk("basic_busy_n7", int'(busy), 0);
    wait_done("basic");

    // address wrap
    do_start(16'hFFFE, 4);
    wait_done("wrap");

    // backpressure 1,0,0,1
    do_start(16'h0040, 8);
    for (int k = 0; k < 200 && !done; k++) begin
      out_ready = pat[k % 4];
      tick;
    end
    out_ready = 1'b1;
    wait_done("bp");

    // zero length
    do_start(16'h0123, 0);
    chk("zero_done_n1", int'(done), 1);
    chk("zero_busy_n1", int'(busy), 0);
    chk("zero_re_n1", int'(read_enable), 0);
    tick;
    chk("zero_done_n2", int'(done), 0);
    chk("zero_busy_n2", int'(busy), 0);

    // abort two cycles after first out_valid
    do_start(16'h0080, 16);
    tick;
    tick;
    chk("abort_first_ov", int'(out_valid), 1);
    tick;
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    chk("abort_ov", int'(out_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_re", int'(read_enable), 0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", int'(done), 0);
      tick;
    end
    do_start(16'h0020, 3);
    wait_done("post_abort");

    // start while busy is ignored
    do_start(16'h0030, 6);
    tick;
    start_address = 16'h0099;
    read_length = 17'd2;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done("ign_start");

    // reset mid-burst
    do_start(16'h0050, 8);
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    exp_addr.delete();
    exp_data.delete();
    chk_reset_outs("midrst");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("midrst_no_done", int'(done), 0);
      tick;
    end

    // single-word burst after reset
    do_start(16'h00A5, 1);
    wait_done("len1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_read_streamer.md
BRAM_READ_STREAMER -- requirements
Module: bram_read_streamer

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 8, meaning the data word width, which matches block RAM width.
REQ-002 SHALL have parameter RAM_ADDR_BITS, default 16, meaning the RAM address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin a burst.
REQ-006 SHALL have port abort, input, 1 bit: terminates the burst in progress.
REQ-007 SHALL have port start_address, input, RAM_ADDR_BITS: first word address, sampled when start is accepted.
REQ-008 SHALL have port read_length, input, RAM_ADDR_BITS+1: word count, sampled when start is accepted.
REQ-009 SHALL have port read_enable, output, 1 bit: RAM read strobe.
REQ-010 SHALL have port read_address, output, RAM_ADDR_BITS: RAM read address.
REQ-011 SHALL have port read_data, input, RAM_WIDTH: RAM registered read data, valid the cycle after read_enable.
REQ-012 SHALL have port out_data, output, RAM_WIDTH: stream data to the SPI shifter.
REQ-013 SHALL have port out_valid, output, 1 bit: out_data holds a word.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts the word when out_valid is also high.
REQ-015 SHALL have port busy, output, 1 bit: high while a burst is in progress.
REQ-016 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, FETCH and DRAIN.
- IDLE->FETCH on start with read_length>0.
- FETCH->DRAIN when the last read is issued.
- DRAIN->IDLE when the last word is accepted.
REQ-018 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-019 SHALL, on start with read_length==0, issue no reads, stay in IDLE, and pulse done in the next cycle.
REQ-020 SHALL, when start is accepted in cycle N, assert read_enable in cycle N+1 with read_address=start_address.
REQ-021 SHALL, with out_ready held high, assert out_valid first in cycle N+3 and sustain one word per cycle with no bubbles.
REQ-022 SHALL increment read_address by 1 per issued read, wrapping from 2**RAM_ADDR_BITS-1 to 0.
REQ-023 SHALL issue exactly read_length reads per burst; a read_length of 2**RAM_ADDR_BITS reads every location once.
REQ-024 SHALL buffer returned data in a 2-entry FIFO.
- A read issues only when (occupancy + reads in flight - pop this cycle) < 2.
- No word is ever dropped or duplicated.
REQ-025 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-026 SHALL deliver words in address order.
REQ-027 SHALL pulse done for one cycle in the cycle after the handshake of the final word, and return to IDLE in that same cycle.
REQ-028 SHALL, on abort in any state, in the next cycle:
- go to IDLE;
- deassert read_enable, out_valid and busy;
- flush the FIFO;
- discard any in-flight return;
- not pulse done.
REQ-029 SHALL give abort priority over start when both are high in the same cycle.
REQ-030 SHALL keep busy high from the cycle after start is accepted until the cycle done pulses or abort is taken.
REQ-031 SHALL keep read_enable low in IDLE and DRAIN.

Reset
REQ-032 SHALL, while rst=1, drive:
- state=IDLE;
- read_enable=0, read_address=0;
- out_valid=0, out_data=0;
- busy=0, done=0;
- FIFO empty, counters 0.
REQ-033 SHALL, on rst asserted mid-burst, discard the burst with no done pulse, taking effect at the next edge.

Structure
REQ-034 SHALL take the state enum typedef from a shared package, adc_bram_pkg, which the other ADC/BRAM blocks also use.
REQ-035 SHALL implement the 2-entry buffer as sub-module skid_fifo2, parameterised by RAM_WIDTH, with push/pop/occupancy ports.
REQ-036 SHALL connect read_enable, read_address and read_data directly to the read port of the existing dual-port block RAM, with no glue logic.

Verification
REQ-037 SHALL verify basic burst: RAM preloaded with data[a]=a[7:0]; start_address=0x0010, length=4, out_ready=1 -> out_data 0x10,0x11,0x12,0x13 in cycles N+3..N+6, done at N+7.
REQ-038 SHALL verify wrap: start_address=0xFFFE, length=4 -> reads at FFFE, FFFF, 0000, 0001; data 0xFE,0xFF,0x00,0x01.
REQ-039 SHALL verify backpressure: length=8, out_ready toggles 1,0,0,1 repeating -> all 8 words delivered in order, none lost, read_enable never issued with 2 words buffered or in flight.
REQ-040 SHALL verify zero length: start with length=0 -> read_enable stays 0, busy stays 0, done pulses at N+1.
REQ-041 SHALL verify abort: abort asserted 2 cycles after the first out_valid of a length-16 burst -> out_valid=0 and busy=0 in the next cycle, no done; a following start delivers correct data.
REQ-042 SHALL verify reset mid-burst and ignored start: start while busy has no effect on the burst; rst mid-burst -> all outputs at reset values the next cycle.
